// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage for the 9-bit CPU.
// Owns the program counter, drives the synchronous instruction ROM and
// hands one instruction per cycle to the decoder. Accepts halt (done),
// absolute jump and PC-relative branch requests back from the decoder.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 begin execution at RESET_PC (IDLE/HALT only)
//   done                  halt request for the current instruction
//   stall                 freeze fetch (state, pc, imem_addr, instr held)
//   jump_en, jump_target  absolute redirect
//   rel_en, rel_offset    relative branch, signed offset from pc
//   imem_addr, imem_data  ROM address out, ROM data back one cycle later
//   instr, instr_valid    instruction to decoder (NOP when not valid)
//   pc                    address of instr
//   busy, halted          status (RUN/BUBBLE, HALT)
//
// state  | meaning
// IDLE   | after reset, waiting for start
// RUN    | instr holds a valid instruction every non-stalled cycle
// BUBBLE | redirect taken; ROM data is the squashed fall-through fetch
// HALT   | done seen; waiting for start
module instr_fetch #(
  parameter int          PC_W     = 10,
  parameter int          OFF_W    = 8,
  parameter int          RESET_PC = 0,
  parameter logic [8:0]  NOP      = 9'h022
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             done,
  input  logic             stall,
  input  logic             jump_en,
  input  logic [PC_W-1:0]  jump_target,
  input  logic             rel_en,
  input  logic [OFF_W-1:0] rel_offset,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [8:0]       imem_data,
  output logic [8:0]       instr,
  output logic             instr_valid,
  output logic [PC_W-1:0]  pc,
  output logic             busy,
  output logic             halted
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_BUBBLE = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] addr_q, addr_d;
  logic            stalled_q, stalled_d;
  logic [8:0]      hold_q, hold_d;
  logic [PC_W-1:0] rel_target;

  // Offset is sign-extended to PC_W; the add wraps modulo 2^PC_W.
  assign rel_target = pc_q + {{(PC_W-OFF_W){rel_offset[OFF_W-1]}}, rel_offset};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RST_PC;
      addr_q    <= RST_PC;
      stalled_q <= 1'b0;
      hold_q    <= NOP;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      stalled_q <= stalled_d;
      hold_q    <= hold_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    stalled_d = 1'b0;
    hold_d    = hold_q;

    unique case (state_q)
      S_IDLE, S_HALT: begin
        addr_d = RST_PC;
        if (start) begin
          state_d = S_RUN;
          pc_d    = RST_PC;
          addr_d  = RST_PC + PC_W'(1);
        end
      end
      S_RUN: begin
        if (stall) begin
          // The ROM keeps reading the held address (pc+1), so its output
          // moves on after the first stalled cycle. Capture the current
          // instruction once and present it for the rest of the stall.
          stalled_d = 1'b1;
          if (!stalled_q) hold_d = imem_data;
        end else if (done) begin
          state_d = S_HALT;
          addr_d  = RST_PC;
        end else if (jump_en) begin
          state_d = S_BUBBLE;
          pc_d    = jump_target;
          addr_d  = jump_target;
        end else if (rel_en) begin
          state_d = S_BUBBLE;
          pc_d    = rel_target;
          addr_d  = rel_target;
        end else begin
          pc_d   = addr_q;
          addr_d = addr_q + PC_W'(1);
        end
      end
      S_BUBBLE: begin
        if (!stall) begin
          state_d = S_RUN;
          addr_d  = pc_q + PC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_addr   = addr_q;
  assign pc          = pc_q;
  assign instr_valid = (state_q == S_RUN);
  assign instr       = !instr_valid ? NOP : (stalled_q ? hold_q : imem_data);
  assign busy        = (state_q == S_RUN) || (state_q == S_BUBBLE);
  assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       reset, start, done, stall, jump_en, rel_en;
  logic [9:0] jump_target;
  logic [7:0] rel_offset;
  logic [9:0] imem_addr;
  logic [8:0] imem_data = 9'h000;
  logic [8:0] instr;
  logic       instr_valid;
  logic [9:0] pc;
  logic       busy, halted;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] rom [1024];

  instr_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .done        (done),
    .stall       (stall),
    .jump_en     (jump_en),
    .jump_target (jump_target),
    .rel_en      (rel_en),
    .rel_offset  (rel_offset),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= rom[imem_addr];

  // ROM word at address a is (a + 0x101) mod 512, so ROM[0..3] = 101..104.
  function automatic logic [8:0] rom_val(input logic [9:0] a);
    logic [10:0] s;
    s = {1'b0, a} + 11'h101;
    return s[8:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_run(input string tag, input logic [9:0] exp_pc);
    chk({tag, ".valid"}, 32'(instr_valid), 32'd1);
    chk({tag, ".pc"},    32'(pc),          32'(exp_pc));
    chk({tag, ".instr"}, 32'(instr),       32'(rom_val(exp_pc)));
    chk({tag, ".busy"},  32'(busy),        32'd1);
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".valid"}, 32'(instr_valid), 32'd0);
    chk({tag, ".instr"}, 32'(instr),       32'h022);
    chk({tag, ".busy"},  32'(busy),        32'd1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = rom_val(10'(i));
    reset = 1'b1; start = 1'b0; done = 1'b0; stall = 1'b0;
    jump_en = 1'b0; rel_en = 1'b0; jump_target = '0; rel_offset = '0;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst.valid",  32'(instr_valid), 32'd0);
    chk("rst.pc",     32'(pc),          32'd0);
    chk("rst.addr",   32'(imem_addr),   32'd0);
    chk("rst.busy",   32'(busy),        32'd0);
    chk("rst.halted", 32'(halted),      32'd0);
    chk("rst.instr",  32'(instr),       32'h022);

    // start: first valid instruction one cycle later
    start = 1'b1; step(); start = 1'b0;
    chk_run("seq0", 10'd0);
    chk("seq0.addr", 32'(imem_addr), 32'd1);
    chk("seq0.instr_lit", 32'(instr), 32'h101);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk_run("seq", 10'(i));
    end
    chk("seq3.instr_lit", 32'(rom_val(10'd3)), 32'h104);

    // relative branch -5 at pc=5 -> bubble -> pc=0
    rel_en = 1'b1; rel_offset = 8'hFB; step(); rel_en = 1'b0;
    chk_bubble("rel1.bub");
    step();
    chk_run("rel1.tgt", 10'd0);
    step(); step();
    chk_run("rel2.pre", 10'd2);

    // relative branch -4 at pc=2 -> wraps to 1022
    rel_en = 1'b1; rel_offset = 8'hFC; step(); rel_en = 1'b0;
    chk_bubble("rel2.bub");
    step();
    chk_run("rel2.tgt", 10'd1022);
    chk("rel2.addr", 32'(imem_addr), 32'd1023);
    step();
    chk_run("wrap1023", 10'd1023);
    step();
    chk_run("wrap0", 10'd0);
    for (int i = 1; i <= 4; i++) step();
    chk_run("stall.pre", 10'd4);

    // stall 3 cycles at pc=4, jump pulse inside is ignored
    stall = 1'b1; step();
    chk_run("stall1", 10'd4);
    chk("stall1.addr", 32'(imem_addr), 32'd5);
    jump_en = 1'b1; jump_target = 10'h200; step(); jump_en = 1'b0;
    chk_run("stall2", 10'd4);
    chk("stall2.addr", 32'(imem_addr), 32'd5);
    step();
    chk_run("stall3", 10'd4);
    chk("stall3.addr", 32'(imem_addr), 32'd5);
    stall = 1'b0; step();
    chk_run("stall.rel", 10'd5);
    step(); step();
    chk_run("jr.pre", 10'd7);

    // jump and rel together: jump wins
    jump_en = 1'b1; rel_en = 1'b1; jump_target = 10'h200; rel_offset = 8'h03;
    step(); jump_en = 1'b0; rel_en = 1'b0;
    chk_bubble("jr.bub");
    step();
    chk_run("jr.tgt", 10'h200);
    chk("jr.addr", 32'(imem_addr), 32'h201);

    // get to pc=6 via jump
    jump_en = 1'b1; jump_target = 10'd6; step(); jump_en = 1'b0;
    chk_bubble("j6.bub");
    step();
    chk_run("j6.tgt", 10'd6);

    // done beats jump
    done = 1'b1; jump_en = 1'b1; jump_target = 10'h055; step();
    done = 1'b0; jump_en = 1'b0;
    chk("halt.halted", 32'(halted),      32'd1);
    chk("halt.busy",   32'(busy),        32'd0);
    chk("halt.valid",  32'(instr_valid), 32'd0);
    chk("halt.instr",  32'(instr),       32'h022);
    chk("halt.addr",   32'(imem_addr),   32'd0);
    step();
    chk("halt2.halted", 32'(halted),      32'd1);
    chk("halt2.valid",  32'(instr_valid), 32'd0);

    // start honoured from HALT even with stall high
    start = 1'b1; stall = 1'b1; step(); start = 1'b0; stall = 1'b0;
    chk_run("restart", 10'd0);
    chk("restart.halted", 32'(halted), 32'd0);
    step();
    chk_run("restart1", 10'd1);

    // reset during a bubble, with stall high
    jump_en = 1'b1; jump_target = 10'h010; step(); jump_en = 1'b0;
    chk_bubble("rb.bub");
    reset = 1'b1; stall = 1'b1; step(); reset = 1'b0; stall = 1'b0;
    chk("rb.valid",  32'(instr_valid), 32'd0);
    chk("rb.pc",     32'(pc),          32'd0);
    chk("rb.addr",   32'(imem_addr),   32'd0);
    chk("rb.busy",   32'(busy),        32'd0);
    chk("rb.halted", 32'(halted),      32'd0);
    step();
    chk("rb.idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
